// File: rtl/si_dac_multi.sv
// Multi-channel serial-input DAC model: addressed frames load per-channel input registers, soc/auto-update moves them to DAC registers.
// Latency: commit on the edge sampling SI_en=0 after a full frame; soc copies on its sampling edge; A_out follows dac_reg combinationally.
// Backpressure: none; SI is consumed every enabled edge, bad frames are dropped with a one-cycle frame_err pulse.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   SI         serial data, MSB first, sampled while SI_en=1
//   SI_en      frame enable / chip select, active-high
//   soc        start of conversion: copy every input register to its DAC register
//   SO         daisy-chain output, SI delayed by FRAME_LEN enabled edges
//   busy       high while a frame is being received
//   frame_err  one-cycle pulse when a frame is rejected (short, long or bad address)
//   A_out      per-channel analog output, dac_reg * VREF / 2**N
//
// Parameter ranges: N 2..16, CHANNELS 1..8, 2**ADDR_W >= CHANNELS.

module si_dac_multi #(
  parameter int  N        = 12,
  parameter int  CHANNELS = 4,
  parameter int  ADDR_W   = 2,
  parameter int  AUTO_UPD = 0,
  parameter real VREF     = 1.0
) (
  input  logic clk,
  input  logic rst,
  input  logic SI,
  input  logic SI_en,
  input  logic soc,
  output logic SO,
  output logic busy,
  output logic frame_err,
  output real  A_out [CHANNELS]
);

  localparam int  FRAME_LEN  = ADDR_W + N;
  localparam int  CNT_W      = $clog2(FRAME_LEN + 1);
  // Address field is at least one bit wide so a single-channel build with
  // ADDR_W=0 still has a legal vector; it is tied to zero in that case.
  localparam int  AW         = (ADDR_W > 0) ? ADDR_W : 1;
  localparam real FULL_SCALE = 2.0 ** N;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic                 ovf;
  logic                 ovf_nxt;
  logic                 commit;
  logic                 reject;
  logic                 addr_ok;

  // The frame shift register doubles as the daisy-chain delay line: it is
  // FRAME_LEN deep, advances only on enabled edges, and its oldest bit is SO.
  logic [FRAME_LEN-1:0] shift_reg;
  logic [AW-1:0]        frame_addr;
  logic [N-1:0]         frame_data;

  logic [N-1:0]         in_reg  [CHANNELS];
  logic [N-1:0]         dac_reg [CHANNELS];

  // Frame field extraction: address occupies the oldest bits, data the newest.
  generate
    if (ADDR_W > 0) begin : g_addr
      assign frame_addr = shift_reg[FRAME_LEN-1 -: AW];
    end else begin : g_no_addr
      assign frame_addr = '0;
    end
  endgenerate

  assign frame_data = shift_reg[N-1:0];
  assign addr_ok    = (int'(frame_addr) < CHANNELS);
  assign SO         = shift_reg[FRAME_LEN-1];
  assign busy       = (state != IDLE);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and frame decisions
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    commit    = 1'b0;
    reject    = 1'b0;

    case (state)
      IDLE: begin
        if (SI_en) begin
          cnt_nxt   = CNT_W'(1);
          ovf_nxt   = 1'b0;
          state_nxt = (FRAME_LEN == 1) ? FULL : SHIFT;
        end
      end

      SHIFT: begin
        if (SI_en) begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt_nxt == CNT_W'(FRAME_LEN)) begin
            state_nxt = FULL;
          end
        end else begin
          // Chip select dropped before the frame filled up.
          reject    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end

      FULL: begin
        if (SI_en) begin
          // Extra bits keep flowing to SO but poison this frame.
          ovf_nxt = 1'b1;
        end else begin
          if (!ovf && addr_ok) begin
            commit = 1'b1;
          end else begin
            reject = 1'b1;
          end
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        ovf_nxt   = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift register / delay line and error pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      frame_err <= 1'b0;
    end else begin
      if (SI_en) begin
        shift_reg <= {shift_reg[FRAME_LEN-2:0], SI};
      end
      frame_err <= reject;
    end
  end

  // ---------------------------------------------------------------------------
  // Input and DAC registers
  // ---------------------------------------------------------------------------
  // Ordering inside the loop matters: soc takes the pre-edge in_reg value,
  // and with AUTO_UPD a same-edge commit overrides that copy for its channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        in_reg[i]  <= '0;
        dac_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (commit && (int'(frame_addr) == i)) begin
          in_reg[i] <= frame_data;
        end
        if (soc) begin
          dac_reg[i] <= in_reg[i];
        end
        if ((AUTO_UPD != 0) && commit && (int'(frame_addr) == i)) begin
          dac_reg[i] <= frame_data;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Analog outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      A_out[i] = real'(dac_reg[i]) * VREF / FULL_SCALE;
    end
  end

endmodule

// File: tb/tb_si_dac_multi.sv
// Bench for si_dac_multi: three instances share one serial stream
// (4ch manual update, 4ch auto update, 3ch manual update) and are checked
// against a transaction-level model plus a queue of expected frame outcomes.

module tb_si_dac_multi;

  localparam int  FL = 14;
  localparam real VR = 2.5;

  logic clk = 1'b0;
  logic rst;
  logic si;
  logic si_en;
  logic soc;

  logic so0, busy0, err0;
  logic so1, busy1, err1;
  logic so2, busy2, err2;
  real  a0 [4];
  real  a1 [4];
  real  a2 [3];

  int n_assert = 0;
  int n_fail   = 0;

  // transaction-level model
  int m_in  [3][4];
  int m_dac [3][4];
  int n_ch    [3] = '{4, 4, 3};
  int is_auto [3] = '{0, 1, 0};
  int exp_pulses [3] = '{0, 0, 0};
  int got_pulses [3] = '{0, 0, 0};

  // scoreboard: per-frame expected frame_err bits for the three instances
  logic [2:0] err_q [$];
  // history of enabled SI samples for the daisy-chain check
  logic       hist  [$];

  si_dac_multi #(.N(12), .CHANNELS(4), .ADDR_W(2), .AUTO_UPD(0), .VREF(VR)) u_man (
    .clk(clk), .rst(rst), .SI(si), .SI_en(si_en), .soc(soc),
    .SO(so0), .busy(busy0), .frame_err(err0), .A_out(a0)
  );

  si_dac_multi #(.N(12), .CHANNELS(4), .ADDR_W(2), .AUTO_UPD(1), .VREF(VR)) u_auto (
    .clk(clk), .rst(rst), .SI(si), .SI_en(si_en), .soc(soc),
    .SO(so1), .busy(busy1), .frame_err(err1), .A_out(a1)
  );

  si_dac_multi #(.N(12), .CHANNELS(3), .ADDR_W(2), .AUTO_UPD(0), .VREF(VR)) u_ch3 (
    .clk(clk), .rst(rst), .SI(si), .SI_en(si_en), .soc(soc),
    .SO(so2), .busy(busy2), .frame_err(err2), .A_out(a2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input real obs, input real exp);
    n_assert++;
    if ((obs - exp > 1.0e-6) || (exp - obs > 1.0e-6)) begin
      n_fail++;
      $display("FAIL %s: observed %g expected %g", tag, obs, exp);
    end
  endtask

  function automatic real code_v(input int c);
    return real'(c) * VR / 4096.0;
  endfunction

  function automatic real aout(input int inst, input int ch);
    case (inst)
      0:       return a0[ch];
      1:       return a1[ch];
      default: return a2[ch];
    endcase
  endfunction

  task automatic check_all(input string tag);
    for (int inst = 0; inst < 3; inst++) begin
      for (int ch = 0; ch < n_ch[inst]; ch++) begin
        check($sformatf("%s i%0d c%0d", tag, inst, ch), aout(inst, ch), code_v(m_dac[inst][ch]));
      end
    end
  endtask

  task automatic model_clear();
    for (int inst = 0; inst < 3; inst++) begin
      for (int ch = 0; ch < 4; ch++) begin
        m_in[inst][ch]  = 0;
        m_dac[inst][ch] = 0;
      end
    end
  endtask

  task automatic model_soc();
    for (int inst = 0; inst < 3; inst++) begin
      for (int ch = 0; ch < 4; ch++) begin
        m_dac[inst][ch] = m_in[inst][ch];
      end
    end
  endtask

  // Drives nbits of {addr, data, 1}: 14 = well-formed, fewer = short, 15 = long.
  task automatic send_frame(input logic [1:0] addr, input logic [11:0] data,
                            input int nbits, input bit with_soc);
    logic [14:0] pat;
    logic [2:0]  e;
    logic [2:0]  got;
    pat = {addr, data, 1'b1};
    for (int k = 0; k < nbits; k++) begin
      @(negedge clk);
      si_en = 1'b1;
      si    = pat[14-k];
    end
    @(negedge clk);
    check("busy_in_frame", busy0, 1.0);
    si_en = 1'b0;
    si    = 1'b0;
    soc   = with_soc;

    if (with_soc) model_soc();
    for (int inst = 0; inst < 3; inst++) begin
      if ((nbits == FL) && (int'(addr) < n_ch[inst])) begin
        e[inst] = 1'b0;
        m_in[inst][addr] = int'(data);
        if (is_auto[inst] != 0) m_dac[inst][addr] = int'(data);
      end else begin
        e[inst] = 1'b1;
        exp_pulses[inst]++;
      end
    end
    err_q.push_back(e);

    @(posedge clk);
    #1;
    got = err_q.pop_front();
    check("frame_err man",  err0, got[0]);
    check("frame_err auto", err1, got[1]);
    check("frame_err ch3",  err2, got[2]);
    check("busy_after_frame", busy0, 0.0);
    check_all("frame");
    @(negedge clk);
    soc = 1'b0;
  endtask

  task automatic pulse_soc();
    @(negedge clk);
    soc = 1'b1;
    check_all("pre_soc");
    model_soc();
    @(posedge clk);
    #1;
    check_all("soc");
    @(negedge clk);
    soc = 1'b0;
  endtask

  // Daisy-chain and pulse-width monitor.
  always begin
    logic e_so;
    @(posedge clk);
    if (rst) hist.delete();
    else if (si_en) hist.push_back(si);
    #1;
    e_so = 1'b0;
    if (hist.size() >= FL) e_so = hist[hist.size() - FL];
    check("so man", so0, e_so);
    check("so ch3", so2, e_so);
    if (err0) got_pulses[0]++;
    if (err1) got_pulses[1]++;
    if (err2) got_pulses[2]++;
  end

  initial begin
    rst   = 1'b1;
    si    = 1'b0;
    si_en = 1'b0;
    soc   = 1'b0;
    model_clear();

    repeat (2) @(negedge clk);
    check("rst busy", busy0, 0.0);
    check("rst frame_err", err0, 0.0);
    check("rst so", so0, 0.0);
    check_all("reset");
    rst = 1'b0;

    // single frame, manual update only on soc
    send_frame(2'd1, 12'h800, 14, 1'b0);
    check("t1 man before soc", a0[1], 0.0);
    check("t1 auto immediate", a1[1], 1.25);
    pulse_soc();
    check("t1 man after soc", a0[1], 1.25);
    check("t1 man ch0", a0[0], 0.0);

    // load three channels, one simultaneous update
    send_frame(2'd0, 12'hFFF, 14, 1'b0);
    send_frame(2'd2, 12'h400, 14, 1'b0);
    send_frame(2'd3, 12'h001, 14, 1'b0);
    check("t2 ch0 held", a0[0], 0.0);
    pulse_soc();
    check("t2 ch0", a0[0], 2.49939);
    check("t2 ch2", a0[2], 0.625);
    check("t2 ch3", a0[3], 0.00061);

    // short and long frames are rejected
    send_frame(2'd2, 12'h111, 10, 1'b0);
    send_frame(2'd2, 12'h222, 15, 1'b0);
    pulse_soc();
    check("t3 ch2 unchanged", a0[2], 0.625);

    // auto update, then soc coincident with commit
    send_frame(2'd3, 12'hC00, 14, 1'b0);
    check("t4 auto ch3", a1[3], 1.875);
    send_frame(2'd3, 12'h123, 14, 1'b1);
    check("t4 man soc old value", a0[3], 1.875);
    check("t4 auto new wins", a1[3], code_v(12'h123));
    pulse_soc();
    check("t4 man new value", a0[3], code_v(12'h123));

    // reset in the middle of a frame
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      si_en = 1'b1;
      si    = k[0];
    end
    @(negedge clk);
    check("mid busy before rst", busy0, 1.0);
    rst   = 1'b1;
    si_en = 1'b0;
    si    = 1'b0;
    #1;
    model_clear();
    check("mid rst busy man", busy0, 0.0);
    check("mid rst busy auto", busy1, 0.0);
    check("mid rst busy ch3", busy2, 0.0);
    check("mid rst so auto", so1, 0.0);
    check_all("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    send_frame(2'd2, 12'h5A5, 14, 1'b0);
    pulse_soc();
    check("t6 ch2", a0[2], code_v(12'h5A5));

    repeat (3) @(negedge clk);
    for (int inst = 0; inst < 3; inst++) begin
      check($sformatf("pulse count i%0d", inst), real'(got_pulses[inst]), real'(exp_pulses[inst]));
    end
    check("scoreboard drained", real'(err_q.size()), 0.0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
